// File: rtl/hs_pkg.sv
// hs_pkg: shared FSM state encoding and parameter defaults for the hs_rx receiver
package hs_pkg;
    localparam int HS_WIDTH_DEF = 8;
    localparam int HS_SYNC_DEF  = 2;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ACK   = 2'd2
    } hs_state_e;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: STAGES-deep single-bit synchronizer, asynchronously reset to 0
//   sclk  - destination clock
//   reset - asynchronous active-high reset
//   d     - asynchronous input level
//   q     - synchronized level
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic sclk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge sclk or posedge reset)
        if (reset) ff <= '0;
        else       ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/hs_rx.sv
// hs_rx: 4-phase bundled-data receiver with a one-word holding register
//   sclk      - single clock, all flops on its rising edge
//   reset     - asynchronous active-high reset
//   req_a     - asynchronous 4-phase request level from the sender
//   data_a    - bundled data, stable while req_a is high
//   ack       - registered 4-phase acknowledge back to the sender
//   out_valid - holding register contains a word
//   out_ready - consumer accepts the word when out_valid is also high
//   out_data  - held word
//   err       - sticky flag for a request withdrawn while stalled (HS_RX_CHK_EN only)
// Optional macro HS_RX_CHK_EN compiles in the err port and its checker.
module hs_rx
    import hs_pkg::*;
#(
    parameter int WIDTH       = HS_WIDTH_DEF,
    parameter int SYNC_STAGES = HS_SYNC_DEF
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef HS_RX_CHK_EN
    ,
    output logic             err
`endif
);
    logic      req_s;
    logic      free;
    logic      cap;
    hs_state_e state;
    hs_state_e nxt;

    bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .sclk (sclk),
        .reset(reset),
        .d    (req_a),
        .q    (req_s)
    );

    // The register is free if empty or being drained on this same edge.
    always_comb begin
        free = !out_valid || out_ready;
        nxt  = (state == ACK) ? (req_s ? ACK : IDLE)
                              : (!req_s ? IDLE : (free ? ACK : STALL));
        cap  = (state != ACK) && req_s && free;
    end

    // ack is its own flop so the sender never sees a decode glitch.
    always_ff @(posedge sclk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            ack       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= nxt;
            ack   <= (nxt == ACK);
            if (cap) begin
                out_valid <= 1'b1;
                out_data  <= data_a;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end

`ifdef HS_RX_CHK_EN
    // STALL is only entered with req_s high, so req_s low there is a withdrawal.
    always_ff @(posedge sclk or posedge reset)
        if (reset)                          err <= 1'b0;
        else if (state == STALL && !req_s) err <= 1'b1;
`endif
endmodule

// File: doc/hs_rx.md
HS_RX -- requirements
Module: hs_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bundled data width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, req synchronizer depth (legal 2..4).
REQ-003 SHALL have port sclk, input, 1, the single clock; all flops on posedge sclk.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port req_a, input, 1, asynchronous 4-phase request level from the sender domain.
REQ-006 SHALL have port data_a, input, WIDTH, bundled data; the sender holds it stable while req_a is high.
REQ-007 SHALL have port ack, output, 1, registered 4-phase acknowledge level returned to the sender.
REQ-008 SHALL have port out_valid, output, 1, captured word available to the local consumer.
REQ-009 SHALL have port out_ready, input, 1, local consumer accepts the word when out_valid and out_ready are both 1.
REQ-010 SHALL have port out_data, output, WIDTH, captured word, stable while out_valid is 1.
REQ-011 SHALL have port err, output, 1, sticky protocol-violation flag; present only with HS_RX_CHK_EN.

Function
REQ-012 SHALL pass req_a through SYNC_STAGES flops to form req_s; no other logic shall use req_a.
REQ-013 SHALL implement FSM states IDLE (ack=0), STALL (ack=0, request pending, holding register full) and ACK (ack=1).
REQ-014 In IDLE with req_s=1, SHALL capture data_a into out_data, set out_valid and ack, and go to ACK, if the holding register is free.
REQ-015 The holding register is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (accept and capture on the same edge).
REQ-016 In IDLE with req_s=1 and the holding register not free, SHALL go to STALL with no capture; STALL does the capture and moves to ACK once the register is free.
REQ-017 In ACK, SHALL hold ack=1 until req_s=0, then clear ack and return to IDLE on that edge.
REQ-018 SHALL clear out_valid on out_valid and out_ready, unless a capture occurs on the same edge.
REQ-019 Latency: ack and out_valid rise SYNC_STAGES+1 sclk edges after req_a is first sampled high, with the register free; ack falls SYNC_STAGES+1 edges after req_a is sampled low.
REQ-020 SHALL capture exactly one word per req_a high phase; req_s held high in ACK SHALL NOT cause recapture.
REQ-021 SHALL keep out_valid, out_data and out_ready behaviour independent of the ack state; the consumer may accept while in ACK.

Reset
REQ-022 On reset assertion, without waiting for a clock edge, SHALL set: FSM to IDLE, synchronizer flops to 0, ack=0, out_valid=0, out_data=0, err=0.
REQ-023 Reset mid-transfer SHALL discard any held word and drop ack; the sender domain is reset together with this block.
REQ-024 Reset deassertion SHALL be synchronized externally to sclk; this block does not re-synchronize it.

Configuration
REQ-025 Macro HS_RX_CHK_EN: when defined, the err port and checker are compiled in.
REQ-026 With HS_RX_CHK_EN, err SHALL set on req_s falling while in STALL (request withdrawn before ack), and clear only on reset.
REQ-027 Without HS_RX_CHK_EN, the err port and checker logic SHALL be absent; in STALL, req_s falling SHALL return the FSM to IDLE with no capture.

Structure
REQ-028 Package hs_pkg SHALL hold the FSM state enum (IDLE, STALL, ACK) and the defaults HS_WIDTH_DEF=8 and HS_SYNC_DEF=2.
REQ-029 SHALL instantiate one sub-module, bit_sync (1-bit, parameter STAGES, asynchronous reset to 0), for the req_a synchronizer.

Verification
REQ-030 Single transfer: SYNC_STAGES=2, data_a=8'hA5, req_a rises, out_ready=1 -> ack=1 and out_valid=1 with out_data=A5 on edge 3; req_a falls -> ack=0 3 edges later.
REQ-031 Backpressure: out_ready=0, two transfers 8'h11 then 8'h22 -> second request held in STALL with ack=0 and out_data=11; out_ready=1 for one cycle -> capture 22 on the same edge, ack rises.
REQ-032 Simultaneous event: out_valid=1 and out_ready=1 on the same edge req_s is seen high -> out_valid stays 1, out_data updates, no bubble cycle.
REQ-033 Reset mid-transfer: assert reset while ack=1 and out_valid=1 -> both 0 immediately, without a clock edge; after release, the next transfer 8'h3C completes normally.
REQ-034 Checker (HS_RX_CHK_EN): drive req_a high and then low while in STALL -> err=1 and stays 1 until reset; without the macro, the FSM returns to IDLE and out_data is unchanged.
REQ-035 Back-to-back: 16 transfers with random req_a gaps of 0..5 sclk and out_ready=1 -> all 16 words received in order, no duplicates.
